// File: rtl/wb_retire_buffer.sv
// rtl/wb_retire_buffer.sv - writeback retire buffer draining results into the register-file write port
// Optional macro WB_RETIRE_FWD_EN compiles operand forwarding from buffered entries.
module wb_retire_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [1:0]  wb_sel,
  input  logic [31:0] wb_alu_result,
  input  logic [31:0] wb_pc_plus4,
  input  logic [31:0] wb_load_data,
  input  logic [1:0]  wb_load_size,
  input  logic        wb_load_unsigned,
  input  logic [1:0]  wb_addr_low,
  input  logic        rf_grant,
  output logic        reg_write_en,
  output logic [4:0]  reg_write_dest,
  output logic [31:0] reg_write_data,
  input  logic [4:0]  fwd_addr_1,
  input  logic [4:0]  fwd_addr_2,
  output logic        fwd_hit_1,
  output logic        fwd_hit_2,
  output logic [31:0] fwd_data_1,
  output logic [31:0] fwd_data_2,
  output logic [63:0] instret
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [4:0]    r_dest [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [63:0]   r_instret;

  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [31:0]   w_wdata;

  assign w_empty  = (r_count == '0);
  assign wb_ready = (r_count < CW'(DEPTH));
  assign w_accept = wb_valid & wb_ready;
  assign w_push   = w_accept & wb_reg_write & (wb_rd != 5'd0);
  assign w_pop    = reg_write_en;
  assign instret  = r_instret;

  // Load alignment: halfword selection only looks at the upper address bit.
  always_comb begin
    w_byte = wb_load_data[{wb_addr_low, 3'b000} +: 8];
    w_half = wb_addr_low[1] ? wb_load_data[31:16] : wb_load_data[15:0];
    case (wb_load_size)
      2'b00:   w_load = wb_load_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = wb_load_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = wb_load_data;
    endcase
    case (wb_sel)
      2'b01:   w_wdata = w_load;
      2'b10:   w_wdata = wb_pc_plus4;
      default: w_wdata = wb_alu_result;
    endcase
  end

  assign reg_write_en   = ~w_empty & rf_grant;
  assign reg_write_dest = w_empty ? 5'd0  : r_dest[r_rptr];
  assign reg_write_data = w_empty ? 32'd0 : r_data[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_instret <= 64'd0;
    end else begin
      if (w_accept) r_instret <= r_instret + 64'd1;
      if (w_push)   r_wptr    <= r_wptr + PW'(1);
      if (w_pop)    r_rptr    <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: validity is carried entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dest[r_wptr] <= wb_rd;
      r_data[r_wptr] <= w_wdata;
    end
  end

`ifdef WB_RETIRE_FWD_EN
  logic [PW-1:0] w_idx;

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_hit_1  = 1'b0;
    fwd_hit_2  = 1'b0;
    fwd_data_1 = 32'd0;
    fwd_data_2 = 32'd0;
    w_idx      = r_rptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + PW'(i);
      if (CW'(i) < r_count) begin
        if ((fwd_addr_1 != 5'd0) && (r_dest[w_idx] == fwd_addr_1)) begin
          fwd_hit_1  = 1'b1;
          fwd_data_1 = r_data[w_idx];
        end
        if ((fwd_addr_2 != 5'd0) && (r_dest[w_idx] == fwd_addr_2)) begin
          fwd_hit_2  = 1'b1;
          fwd_data_2 = r_data[w_idx];
        end
      end
    end
  end
`else
  logic w_fwd_unused;
  assign w_fwd_unused = ^{fwd_addr_1, fwd_addr_2};
  assign fwd_hit_1    = 1'b0;
  assign fwd_hit_2    = 1'b0;
  assign fwd_data_1   = 32'd0;
  assign fwd_data_2   = 32'd0;
`endif

endmodule

// File: tb/tb_wb_retire_buffer.sv
// tb/tb_wb_retire_buffer.sv - scoreboard bench for wb_retire_buffer (DEPTH=2)
module tb_wb_retire_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, wb_ready, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_sel;
  logic [31:0] wb_alu_result, wb_pc_plus4, wb_load_data;
  logic [1:0]  wb_load_size;
  logic        wb_load_unsigned;
  logic [1:0]  wb_addr_low;
  logic        rf_grant;
  logic        reg_write_en;
  logic [4:0]  reg_write_dest;
  logic [31:0] reg_write_data;
  logic [4:0]  fwd_addr_1, fwd_addr_2;
  logic        fwd_hit_1, fwd_hit_2;
  logic [31:0] fwd_data_1, fwd_data_2;
  logic [63:0] instret;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];
  logic [63:0] exp_instret = 64'd0;

  always #5 clk = ~clk;

  wb_retire_buffer #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_sel(wb_sel),
    .wb_alu_result(wb_alu_result), .wb_pc_plus4(wb_pc_plus4), .wb_load_data(wb_load_data),
    .wb_load_size(wb_load_size), .wb_load_unsigned(wb_load_unsigned), .wb_addr_low(wb_addr_low),
    .rf_grant(rf_grant), .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
    .reg_write_data(reg_write_data), .fwd_addr_1(fwd_addr_1), .fwd_addr_2(fwd_addr_2),
    .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2), .fwd_data_1(fwd_data_1),
    .fwd_data_2(fwd_data_2), .instret(instret)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every register-file write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && reg_write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, reg_write_dest, reg_write_data}, 64'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("write_dest", 64'(reg_write_dest), 64'(e[36:32]));
        check("write_data", 64'(reg_write_data), 64'(e[31:0]));
      end
    end
  end

  task automatic send(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] ld,
                      input logic [1:0] sz, input logic uns, input logic [1:0] al,
                      input logic [31:0] exp_data);
    int waited = 0;
    while (!wb_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!wb_ready) begin
      check("ready_timeout", 64'(wb_ready), 64'd1);
      return;
    end
    wb_valid = 1'b1; wb_reg_write = rw; wb_rd = rd; wb_sel = sel;
    wb_alu_result = alu; wb_pc_plus4 = pc4; wb_load_data = ld;
    wb_load_size = sz; wb_load_unsigned = uns; wb_addr_low = al;
    if (rw && rd != 5'd0) exp_q.push_back({rd, exp_data});
    exp_instret++;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_en"},   64'(reg_write_en),   64'd0);
    check({tag, "_dest"}, 64'(reg_write_dest), 64'd0);
    check({tag, "_data"}, 64'(reg_write_data), 64'd0);
    check({tag, "_ready"}, 64'(wb_ready), 64'd1);
    check({tag, "_hit1"}, 64'(fwd_hit_1), 64'd0);
    check({tag, "_fdata1"}, 64'(fwd_data_1), 64'd0);
    check({tag, "_instret"}, instret, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; wb_reg_write = 1'b0; wb_rd = '0; wb_sel = '0;
    wb_alu_result = '0; wb_pc_plus4 = '0; wb_load_data = '0; wb_load_size = '0;
    wb_load_unsigned = 1'b0; wb_addr_low = '0; rf_grant = 1'b1; fwd_addr_1 = '0; fwd_addr_2 = '0;
    #12;
    check_idle_outputs("reset");
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU write with one-cycle latency
    send(1, 5'd1, 2'b00, 32'd100, 0, 0, 2'b00, 0, 2'd0, 32'd100);
    check("alu_latency_en", 64'(reg_write_en), 64'd1);
    check("alu_instret", instret, exp_instret);

    // Load extraction and other result selects, streamed back to back
    send(1, 5'd4, 2'b01, 0, 0, 32'h0000_80F0, 2'b00, 0, 2'd0, 32'hFFFF_FFF0);
    send(1, 5'd6, 2'b01, 0, 0, 32'h0000_80F0, 2'b01, 1, 2'd2, 32'h0000_0000);
    send(1, 5'd6, 2'b01, 0, 0, 32'h0000_80F0, 2'b01, 0, 2'd1, 32'hFFFF_80F0);
    send(1, 5'd7, 2'b01, 0, 0, 32'h0000_80F0, 2'b00, 1, 2'd1, 32'h0000_0080);
    send(1, 5'd8, 2'b01, 0, 0, 32'h0000_80F0, 2'b00, 0, 2'd1, 32'hFFFF_FF80);
    check("stream_ready", 64'(wb_ready), 64'd1);
    send(1, 5'd9, 2'b01, 0, 0, 32'h8000_0001, 2'b11, 0, 2'd3, 32'h8000_0001);
    send(1, 5'd10, 2'b10, 32'd1, 32'h0000_1004, 0, 2'b00, 0, 2'd0, 32'h0000_1004);
    send(1, 5'd11, 2'b11, 32'h55, 32'h99, 0, 2'b00, 0, 2'd0, 32'h0000_0055);
    repeat (2) @(posedge clk); #1;
    check("drain1_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure
    rf_grant = 1'b0;
    send(1, 5'd2, 2'b00, 32'd200, 0, 0, 2'b00, 0, 2'd0, 32'd200);
    send(1, 5'd3, 2'b00, 32'd300, 0, 0, 2'b00, 0, 2'd0, 32'd300);
    check("full_ready", 64'(wb_ready), 64'd0);
    check("held_en", 64'(reg_write_en), 64'd0);
    check("held_dest", 64'(reg_write_dest), 64'd2);
    rf_grant = 1'b1;
    check("full_ready_granted", 64'(wb_ready), 64'd0);
    repeat (2) @(posedge clk); #1;
    check("bp_drained", 64'(exp_q.size()), 64'd0);
    check("bp_idle_en", 64'(reg_write_en), 64'd0);

    // x0 and non-writing instructions retire without a write
    send(1, 5'd0, 2'b00, 32'd999, 0, 0, 2'b00, 0, 2'd0, 32'd999);
    send(0, 5'd5, 2'b00, 32'd999, 0, 0, 2'b00, 0, 2'd0, 32'd999);
    repeat (2) @(posedge clk); #1;
    check("nowrite_instret", instret, exp_instret);

    // Forwarding from buffered entries
    rf_grant = 1'b0;
    send(1, 5'd5, 2'b00, 32'd7, 0, 0, 2'b00, 0, 2'd0, 32'd7);
    send(1, 5'd5, 2'b00, 32'd9, 0, 0, 2'b00, 0, 2'd0, 32'd9);
    fwd_addr_1 = 5'd5; fwd_addr_2 = 5'd3; #1;
`ifdef WB_RETIRE_FWD_EN
    check("fwd_hit1", 64'(fwd_hit_1), 64'd1);
    check("fwd_data1", 64'(fwd_data_1), 64'd9);
`else
    check("fwd_hit1", 64'(fwd_hit_1), 64'd0);
    check("fwd_data1", 64'(fwd_data_1), 64'd0);
`endif
    check("fwd_hit2_miss", 64'(fwd_hit_2), 64'd0);
    fwd_addr_1 = 5'd0; #1;
    check("fwd_x0_hit", 64'(fwd_hit_1), 64'd0);
    rf_grant = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("fwd_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of operation with two entries buffered
    rf_grant = 1'b0;
    send(1, 5'd12, 2'b00, 32'd12, 0, 0, 2'b00, 0, 2'd0, 32'd12);
    send(1, 5'd13, 2'b00, 32'd13, 0, 0, 2'b00, 0, 2'd0, 32'd13);
    fwd_addr_1 = 5'd12;
    @(negedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_instret = 64'd0;
    #1;
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1; rf_grant = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("post_reset_en", 64'(reg_write_en), 64'd0);
    check("post_reset_instret", instret, exp_instret);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_retire_buffer.md
WB_RETIRE_BUFFER -- requirements
Module: wb_retire_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, buffer entries (power of two, 2..8).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port wb_valid, input, 1, writeback stage presents an instruction.
REQ-005 SHALL have port wb_ready, output, 1, buffer can accept; equals count < DEPTH.
REQ-006 SHALL have ports wb_reg_write input 1 (instruction writes rd) and wb_rd input 5 (destination).
REQ-007 SHALL have port wb_sel, input, 2, result select: 00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
REQ-008 SHALL have ports wb_alu_result, wb_pc_plus4, wb_load_data, all input, 32.
REQ-009 SHALL have ports wb_load_size input 2 (00 byte, 01 half, 1x word), wb_load_unsigned input 1, wb_addr_low input 2.
REQ-010 SHALL have port rf_grant, input, 1, register-file write port available this cycle.
REQ-011 SHALL have ports reg_write_en output 1, reg_write_dest output 5, reg_write_data output 32, driving the register-file write port.
REQ-012 SHALL have ports fwd_addr_1, fwd_addr_2 input 5; fwd_hit_1, fwd_hit_2 output 1; fwd_data_1, fwd_data_2 output 32.
REQ-013 SHALL have port instret, output, 64, retired-instruction count.

Function
REQ-014 SHALL accept an instruction on a rising edge where wb_valid and wb_ready are both 1.
REQ-015 SHALL enqueue an accepted instruction only if wb_reg_write=1 and wb_rd!=0; other accepted instructions are retired without enqueue.
REQ-016 SHALL form enqueued data at acceptance: ALU/PC+4 pass-through; load extracts byte at wb_addr_low, half at wb_addr_low[1] (bit 0 ignored), word whole; sign-extend unless wb_load_unsigned=1 (word unaffected).
REQ-017 SHALL, when not empty, present head entry on reg_write_dest/reg_write_data and drive reg_write_en = rf_grant.
REQ-018 SHALL pop head on a rising edge where reg_write_en=1; with push and pop in the same edge, count SHALL remain unchanged.
REQ-019 SHALL drive reg_write_en, reg_write_dest, reg_write_data to 0 when empty.
REQ-020 SHALL have minimum latency of one cycle: accepted at edge N, visible on reg_write_* in cycle after N.
REQ-021 SHALL deassert wb_ready when full regardless of rf_grant (no same-cycle pass-through).
REQ-022 SHALL retire in program order; pointers SHALL wrap modulo DEPTH.
REQ-023 SHALL increment instret by 1 on every accepted instruction, independent of enqueue; wraps at 2^64.
REQ-024 SHALL assert fwd_hit_x when fwd_addr_x!=0 matches any valid entry, returning the youngest matching entry's data; otherwise hit=0, data=0.

Reset
REQ-025 SHALL, on rst_n low, immediately clear count, pointers and instret, and force wb_ready=1, reg_write_en=0, reg_write_dest=0, reg_write_data=0, fwd_hit_x=0, fwd_data_x=0.
REQ-026 SHALL discard all buffered entries on reset mid-operation; no write issues until new acceptance after rst_n rises.

Configuration
REQ-027 SHALL compile forwarding logic only when macro WB_RETIRE_FWD_EN is defined; if undefined, fwd ports remain present with fwd_hit_x and fwd_data_x tied to 0.

Verification
REQ-028 SHALL verify ALU write: sel=00, rd=1, alu=100, rf_grant=1 -> next cycle reg_write_en=1, dest=1, data=100; instret=1.
REQ-029 SHALL verify load extension: load_data=0x0000_80F0, size=byte, addr_low=0, signed -> data 0xFFFF_FFF0; size=half, addr_low=2, unsigned -> data 0x0000_0000.
REQ-030 SHALL verify backpressure: rf_grant=0, accept rd=2 (200), rd=3 (300) -> wb_ready=0; grant=1 -> writes 200 then 300 on consecutive cycles.
REQ-031 SHALL verify x0 and non-writing: rd=0 data=999 or wb_reg_write=0 -> reg_write_en never 1, instret still increments.
REQ-032 SHALL verify forwarding (WB_RETIRE_FWD_EN defined): buffered rd=5 (7) then rd=5 (9), grant=0, fwd_addr_1=5 -> hit=1, data=9; undefined -> hit=0.
REQ-033 SHALL verify reset: two entries buffered, rst_n low mid-cycle -> outputs 0 immediately, instret=0, no write after release.
